// File: rtl/udp_ctrl_demux.sv
// UDP header/payload demultiplexer: frames addressed to CTRL_UDP_PORT on this station go to the controller, others are drained.
// Optional frame counters are built only when UDP_DEMUX_CNT_EN is defined.
module udp_ctrl_demux #(
  parameter logic [15:0] CTRL_UDP_PORT = 16'h6789,
  parameter bit          ACCEPT_BCAST  = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] local_ip,
  input  logic        s_udp_hdr_valid,
  output logic        s_udp_hdr_ready,
  input  logic [12:0] s_ip_fragment_offset,
  input  logic [31:0] s_ip_source_ip,
  input  logic [31:0] s_ip_dest_ip,
  input  logic [15:0] s_udp_source_port,
  input  logic [15:0] s_udp_dest_port,
  input  logic [15:0] s_udp_length,
  input  logic        s_udp_err,
  input  logic [7:0]  s_udp_payload_axis_tdata,
  input  logic        s_udp_payload_axis_tvalid,
  output logic        s_udp_payload_axis_tready,
  input  logic        s_udp_payload_axis_tlast,
  output logic        ctrl_in_udp_hdr_valid,
  input  logic        ctrl_in_udp_hdr_ready,
  output logic [12:0] ctrl_in_ip_fragment_offset,
  output logic [31:0] ctrl_in_ip_source_ip,
  output logic [31:0] ctrl_in_ip_dest_ip,
  output logic [15:0] ctrl_in_udp_source_port,
  output logic [15:0] ctrl_in_udp_dest_port,
  output logic [15:0] ctrl_in_udp_length,
  output logic        ctrl_in_udp_err,
  output logic [7:0]  ctrl_in_udp_payload_axis_tdata,
  output logic        ctrl_in_udp_payload_axis_tvalid,
  input  logic        ctrl_in_udp_payload_axis_tready,
  output logic        ctrl_in_udp_payload_axis_tlast,
  output logic [15:0] fwd_cnt,
  output logic [15:0] drop_cnt
);

  typedef enum logic [1:0] {IDLE, FWD_HDR, FWD_PAY, DROP_PAY} state_t;

  state_t state, state_nxt;
  logic   match;
  logic   hdr_fire;
  logic   ctrl_hdr_fire;

  assign match = (s_udp_dest_port == CTRL_UDP_PORT) &&
                 ((s_ip_dest_ip == local_ip) || (ACCEPT_BCAST && (s_ip_dest_ip == 32'hFFFF_FFFF)));
  assign hdr_fire      = s_udp_hdr_valid && s_udp_hdr_ready;
  assign ctrl_hdr_fire = ctrl_in_udp_hdr_valid && ctrl_in_udp_hdr_ready;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every output of this block is defaulted first, so no path can infer a latch.
  always_comb begin
    state_nxt                       = state;
    s_udp_hdr_ready                 = 1'b0;
    ctrl_in_udp_hdr_valid           = 1'b0;
    s_udp_payload_axis_tready       = 1'b0;
    ctrl_in_udp_payload_axis_tvalid = 1'b0;
    ctrl_in_udp_payload_axis_tdata  = s_udp_payload_axis_tdata;
    ctrl_in_udp_payload_axis_tlast  = s_udp_payload_axis_tlast;
    unique case (state)
      IDLE: begin
        // Held low while reset is asserted so no header is taken during reset.
        s_udp_hdr_ready = !rst;
        if (hdr_fire) begin
          if (match)                    state_nxt = FWD_HDR;
          else if (s_udp_length > 16'd8) state_nxt = DROP_PAY;
        end
      end
      FWD_HDR: begin
        ctrl_in_udp_hdr_valid = 1'b1;
        if (ctrl_in_udp_hdr_ready)
          state_nxt = (ctrl_in_udp_length > 16'd8) ? FWD_PAY : IDLE;
      end
      FWD_PAY: begin
        ctrl_in_udp_payload_axis_tvalid = s_udp_payload_axis_tvalid;
        s_udp_payload_axis_tready       = ctrl_in_udp_payload_axis_tready;
        if (s_udp_payload_axis_tvalid && ctrl_in_udp_payload_axis_tready && s_udp_payload_axis_tlast)
          state_nxt = IDLE;
      end
      DROP_PAY: begin
        s_udp_payload_axis_tready = 1'b1;
        if (s_udp_payload_axis_tvalid && s_udp_payload_axis_tlast)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Header copy is taken on every accepted header; it is only presented when the frame matched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_in_ip_fragment_offset <= '0;
      ctrl_in_ip_source_ip       <= '0;
      ctrl_in_ip_dest_ip         <= '0;
      ctrl_in_udp_source_port    <= '0;
      ctrl_in_udp_dest_port      <= '0;
      ctrl_in_udp_length         <= '0;
      ctrl_in_udp_err            <= 1'b0;
    end else if (hdr_fire) begin
      ctrl_in_ip_fragment_offset <= s_ip_fragment_offset;
      ctrl_in_ip_source_ip       <= s_ip_source_ip;
      ctrl_in_ip_dest_ip         <= s_ip_dest_ip;
      ctrl_in_udp_source_port    <= s_udp_source_port;
      ctrl_in_udp_dest_port      <= s_udp_dest_port;
      ctrl_in_udp_length         <= s_udp_length;
      ctrl_in_udp_err            <= s_udp_err;
    end
  end

`ifdef UDP_DEMUX_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fwd_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      if (ctrl_hdr_fire && (fwd_cnt != 16'hFFFF))        fwd_cnt  <= fwd_cnt + 16'd1;
      if (hdr_fire && !match && (drop_cnt != 16'hFFFF))  drop_cnt <= drop_cnt + 16'd1;
    end
  end
`else
  logic unused_cnt;
  assign unused_cnt = ctrl_hdr_fire;
  assign fwd_cnt    = '0;
  assign drop_cnt   = '0;
`endif

endmodule

// File: tb/tb_udp_ctrl_demux.sv
// Directed self-checking bench for udp_ctrl_demux; counter expectations follow UDP_DEMUX_CNT_EN.
// A second instance with ACCEPT_BCAST=0 is released from reset only for the broadcast step.
module tb_udp_ctrl_demux;

  localparam logic [31:0] LOCAL_IP = 32'h0A00_0002;

  logic        clk = 1'b0;
  logic        rst, rst_nb;
  logic [31:0] local_ip;
  logic        s_udp_hdr_valid;
  logic [12:0] s_ip_fragment_offset;
  logic [31:0] s_ip_source_ip, s_ip_dest_ip;
  logic [15:0] s_udp_source_port, s_udp_dest_port, s_udp_length;
  logic        s_udp_err;
  logic [7:0]  s_tdata;
  logic        s_tvalid, s_tlast;
  logic        ctrl_in_udp_hdr_ready, c_tready;

  logic        s_udp_hdr_ready, s_tready, ctrl_in_udp_hdr_valid;
  logic [12:0] c_frag;
  logic [31:0] c_src_ip, c_dst_ip;
  logic [15:0] c_sport, c_dport, c_len;
  logic        c_err;
  logic [7:0]  c_tdata;
  logic        c_tvalid, c_tlast;
  logic [15:0] fwd_cnt, drop_cnt;

  logic        nb_hdr_ready, nb_tready, nb_hdr_valid;
  logic [12:0] nb_frag;
  logic [31:0] nb_src_ip, nb_dst_ip;
  logic [15:0] nb_sport, nb_dport, nb_len;
  logic        nb_err;
  logic [7:0]  nb_tdata;
  logic        nb_tvalid, nb_tlast;
  logic [15:0] nb_fwd_cnt, nb_drop_cnt;

  int n_pass = 0, n_total = 0;
  int n_fwd = 0, n_drop = 0;

  always #5 clk = ~clk;

  udp_ctrl_demux dut (
    .clk(clk), .rst(rst), .local_ip(local_ip),
    .s_udp_hdr_valid(s_udp_hdr_valid), .s_udp_hdr_ready(s_udp_hdr_ready),
    .s_ip_fragment_offset(s_ip_fragment_offset), .s_ip_source_ip(s_ip_source_ip),
    .s_ip_dest_ip(s_ip_dest_ip), .s_udp_source_port(s_udp_source_port),
    .s_udp_dest_port(s_udp_dest_port), .s_udp_length(s_udp_length), .s_udp_err(s_udp_err),
    .s_udp_payload_axis_tdata(s_tdata), .s_udp_payload_axis_tvalid(s_tvalid),
    .s_udp_payload_axis_tready(s_tready), .s_udp_payload_axis_tlast(s_tlast),
    .ctrl_in_udp_hdr_valid(ctrl_in_udp_hdr_valid), .ctrl_in_udp_hdr_ready(ctrl_in_udp_hdr_ready),
    .ctrl_in_ip_fragment_offset(c_frag), .ctrl_in_ip_source_ip(c_src_ip),
    .ctrl_in_ip_dest_ip(c_dst_ip), .ctrl_in_udp_source_port(c_sport),
    .ctrl_in_udp_dest_port(c_dport), .ctrl_in_udp_length(c_len), .ctrl_in_udp_err(c_err),
    .ctrl_in_udp_payload_axis_tdata(c_tdata), .ctrl_in_udp_payload_axis_tvalid(c_tvalid),
    .ctrl_in_udp_payload_axis_tready(c_tready), .ctrl_in_udp_payload_axis_tlast(c_tlast),
    .fwd_cnt(fwd_cnt), .drop_cnt(drop_cnt)
  );

  udp_ctrl_demux #(.ACCEPT_BCAST(1'b0)) dut_nb (
    .clk(clk), .rst(rst_nb), .local_ip(local_ip),
    .s_udp_hdr_valid(s_udp_hdr_valid), .s_udp_hdr_ready(nb_hdr_ready),
    .s_ip_fragment_offset(s_ip_fragment_offset), .s_ip_source_ip(s_ip_source_ip),
    .s_ip_dest_ip(s_ip_dest_ip), .s_udp_source_port(s_udp_source_port),
    .s_udp_dest_port(s_udp_dest_port), .s_udp_length(s_udp_length), .s_udp_err(s_udp_err),
    .s_udp_payload_axis_tdata(s_tdata), .s_udp_payload_axis_tvalid(s_tvalid),
    .s_udp_payload_axis_tready(nb_tready), .s_udp_payload_axis_tlast(s_tlast),
    .ctrl_in_udp_hdr_valid(nb_hdr_valid), .ctrl_in_udp_hdr_ready(ctrl_in_udp_hdr_ready),
    .ctrl_in_ip_fragment_offset(nb_frag), .ctrl_in_ip_source_ip(nb_src_ip),
    .ctrl_in_ip_dest_ip(nb_dst_ip), .ctrl_in_udp_source_port(nb_sport),
    .ctrl_in_udp_dest_port(nb_dport), .ctrl_in_udp_length(nb_len), .ctrl_in_udp_err(nb_err),
    .ctrl_in_udp_payload_axis_tdata(nb_tdata), .ctrl_in_udp_payload_axis_tvalid(nb_tvalid),
    .ctrl_in_udp_payload_axis_tready(c_tready), .ctrl_in_udp_payload_axis_tlast(nb_tlast),
    .fwd_cnt(nb_fwd_cnt), .drop_cnt(nb_drop_cnt)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [15:0] exp_cnt(input int n);
`ifdef UDP_DEMUX_CNT_EN
    return (n > 65535) ? 16'hFFFF : 16'(n);
`else
    return 16'h0000;
`endif
  endfunction

  task automatic check_cnts(input string tag);
    check({tag, "_fwd_cnt"}, fwd_cnt, exp_cnt(n_fwd));
    check({tag, "_drop_cnt"}, drop_cnt, exp_cnt(n_drop));
  endtask

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic send_hdr(input logic [31:0] src, input logic [31:0] dip, input logic [15:0] dport,
                          input logic [15:0] len, input logic err, input logic [12:0] frag);
    s_ip_source_ip = src; s_ip_dest_ip = dip; s_udp_dest_port = dport;
    s_udp_source_port = src[15:0]; s_udp_length = len; s_udp_err = err;
    s_ip_fragment_offset = frag; s_udp_hdr_valid = 1'b1;
    #1 check("hdr_ready_idle", s_udp_hdr_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    s_udp_hdr_valid = 1'b0;
  endtask

  task automatic check_hdr(input string tag, input logic [31:0] src, input logic [31:0] dip,
                           input logic [15:0] dport, input logic [15:0] len, input logic err,
                           input logic [12:0] frag);
    check({tag, "_valid"}, {ctrl_in_udp_hdr_valid, s_udp_hdr_ready}, 2'b10);
    check({tag, "_ips"}, {c_src_ip, c_dst_ip}, {src, dip});
    check({tag, "_udp"}, {c_sport, c_dport, c_len, c_err, c_frag}, {src[15:0], dport, len, err, frag});
  endtask

  task automatic ctrl_hdr_accept();
    ctrl_in_udp_hdr_ready = 1'b1;
    @(posedge clk);
    n_fwd++;
    @(negedge clk);
    ctrl_in_udp_hdr_ready = 1'b0;
  endtask

  task automatic fwd_payload(input int n, input logic [7:0] base, input bit stall);
    int idx = 0;
    int cyc = 0;
    logic [7:0] d;
    while (idx < n && cyc < 1000) begin
      d = base + 8'(idx);
      s_tvalid = 1'b1; s_tdata = d; s_tlast = (idx == n - 1);
      c_tready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      #1 check("fwd_beat", {c_tvalid, c_tdata, c_tlast, s_tready, s_udp_hdr_ready},
                           {1'b1, d, (idx == n - 1), c_tready, 1'b0});
      @(posedge clk);
      if (c_tready) idx++;
      cyc++;
      @(negedge clk);
    end
    check("fwd_beats_done", idx, n);
    s_tvalid = 1'b0; s_tlast = 1'b0; c_tready = 1'b0;
    #1 check("idle_after_fwd", s_udp_hdr_ready, 1'b1);
  endtask

  task automatic drop_payload(input int n);
    c_tready = 1'b0;
    for (int i = 0; i < n; i++) begin
      s_tvalid = 1'b1; s_tdata = 8'(8'h55 ^ i); s_tlast = (i == n - 1);
      #1 check("drop_beat", {c_tvalid, s_tready, s_udp_hdr_ready}, 3'b010);
      @(posedge clk);
      @(negedge clk);
    end
    s_tvalid = 1'b0; s_tlast = 1'b0;
    #1 check("idle_after_drop", s_udp_hdr_ready, 1'b1);
  endtask

  initial begin
    rst = 1'b1; rst_nb = 1'b1; local_ip = LOCAL_IP;
    s_udp_hdr_valid = 1'b0; s_ip_fragment_offset = '0; s_ip_source_ip = '0; s_ip_dest_ip = '0;
    s_udp_source_port = '0; s_udp_dest_port = '0; s_udp_length = '0; s_udp_err = 1'b0;
    s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0;
    ctrl_in_udp_hdr_ready = 1'b0; c_tready = 1'b0;

    // Reset state
    #12;
    check("rst_outputs", {s_udp_hdr_ready, s_tready, ctrl_in_udp_hdr_valid, c_tvalid}, 4'b0000);
    @(negedge clk);
    rst = 1'b0;
    #1 check("post_rst_hdr_ready", s_udp_hdr_ready, 1'b1);
    check("post_rst_hdr_regs", {c_src_ip, c_dst_ip}, 64'h0);
    check("post_rst_len", {c_len, c_err, c_frag}, 30'h0);
    check_cnts("post_rst");
    @(negedge clk);

    // Matched unicast frame, length 20 -> 12 payload bytes
    send_hdr(32'h0A00_0001, LOCAL_IP, 16'h6789, 16'd20, 1'b1, 13'h1ABC);
    check_hdr("uni_hdr", 32'h0A00_0001, LOCAL_IP, 16'h6789, 16'd20, 1'b1, 13'h1ABC);
    ctrl_hdr_accept();
    fwd_payload(12, 8'h10, 1'b0);
    check_cnts("uni");

    // Wrong port, length 20 -> drained
    @(negedge clk);
    send_hdr(32'h0A00_0003, LOCAL_IP, 16'h1234, 16'd20, 1'b0, 13'h0);
    n_drop++;
    check("drop_no_hdr_valid", ctrl_in_udp_hdr_valid, 1'b0);
    drop_payload(12);
    check_cnts("drop_port");

    // Wrong IP, length 8 -> stays idle, no payload
    send_hdr(32'h0A00_0004, 32'h0A00_0009, 16'h6789, 16'd8, 1'b0, 13'h0);
    n_drop++;
    #1 check("short_drop_idle", {s_udp_hdr_ready, ctrl_in_udp_hdr_valid, s_tready}, 3'b100);
    check_cnts("short_drop");
    @(negedge clk);

    // Broadcast, length 8: forwarded when accepted, dropped by ACCEPT_BCAST=0 instance
    rst_nb = 1'b0;
    send_hdr(32'h0A00_0005, 32'hFFFF_FFFF, 16'h6789, 16'd8, 1'b0, 13'h0005);
    check_hdr("bcast_hdr", 32'h0A00_0005, 32'hFFFF_FFFF, 16'h6789, 16'd8, 1'b0, 13'h0005);
    check("nb_bcast_dropped", {nb_hdr_valid, nb_hdr_ready}, 2'b01);
`ifdef UDP_DEMUX_CNT_EN
    check("nb_bcast_drop_cnt", nb_drop_cnt, 16'd1);
`endif
    rst_nb = 1'b1;
    ctrl_hdr_accept();
    #1 check("bcast_len8_idle", {s_udp_hdr_ready, ctrl_in_udp_hdr_valid}, 2'b10);
    check_cnts("bcast");
    @(negedge clk);

    // Controller stalls header for 50 cycles, then payload with random tready stalls
    send_hdr(32'h0A00_0006, LOCAL_IP, 16'h6789, 16'd24, 1'b0, 13'h0);
    for (int i = 0; i < 50; i++) begin
      s_ip_source_ip = 32'hDEAD_0000 + i; s_udp_length = 16'(i);
      #1 check("stall_hdr", {ctrl_in_udp_hdr_valid, s_udp_hdr_ready, c_src_ip, c_len},
                            {2'b10, 32'h0A00_0006, 16'd24});
      @(negedge clk);
    end
    ctrl_hdr_accept();
    fwd_payload(16, 8'hA0, 1'b1);
    check_cnts("stall");

    // Reset mid-payload
    @(negedge clk);
    send_hdr(32'h0A00_0007, LOCAL_IP, 16'h6789, 16'd20, 1'b0, 13'h0);
    ctrl_hdr_accept();
    s_tvalid = 1'b1; c_tready = 1'b1; s_tdata = 8'h77;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1 check("midrst_outputs", {s_udp_hdr_ready, s_tready, ctrl_in_udp_hdr_valid, c_tvalid}, 4'b0000);
    check("midrst_hdr_regs", {c_src_ip, c_len}, 48'h0);
    n_fwd = 0; n_drop = 0;
    check_cnts("midrst");
    s_tvalid = 1'b0; c_tready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1 check("midrst_release", s_udp_hdr_ready, 1'b1);
    @(negedge clk);
    send_hdr(32'h0A00_0008, LOCAL_IP, 16'h6789, 16'd13, 1'b0, 13'h0);
    check_hdr("after_rst_hdr", 32'h0A00_0008, LOCAL_IP, 16'h6789, 16'd13, 1'b0, 13'h0);
    ctrl_hdr_accept();
    fwd_payload(5, 8'hC0, 1'b1);
    check_cnts("after_rst");

`ifdef UDP_DEMUX_CNT_EN
    // Drop-counter saturation: one short unmatched header per cycle
    @(negedge clk);
    s_ip_dest_ip = 32'h0A00_00FF; s_udp_dest_port = 16'h1111; s_udp_length = 16'd8;
    s_udp_hdr_valid = 1'b1;
    repeat (65540) @(posedge clk);
    n_drop += 65540;
    @(negedge clk);
    s_udp_hdr_valid = 1'b0;
    check_cnts("saturate");
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
